// File: rtl/out_port_arbiter.sv
// rtl/out_port_arbiter.sv - wormhole round-robin output-port arbiter with downstream credit tracking
module out_port_arbiter #(
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       req,
    input  logic [4:0]       tail,
    input  logic             credit_in,
    output logic [4:0]       sel_out,
    output logic [4:0]       rd_en,
    output logic             flit_out_v,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             busy
);
    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [CNT_W-1:0] CRED_MAX = CREDITS[CNT_W-1:0];

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_sel, w_sel_nxt;
    logic [2:0]       r_owner, w_owner_nxt;
    logic [2:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [2:0]       w_winner;
    logic             w_xfer;
    logic [CNT_W-1:0] r_credit_cnt, w_credit_nxt;

    // First requester at or after the pointer, wrapping modulo 5.
    function automatic logic [2:0] rr_pick(input logic [4:0] r, input logic [2:0] p);
        logic [2:0] pick;
        logic [3:0] idx;
        pick = p;
        for (int k = 4; k >= 0; k--) begin
            idx = {1'b0, p} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (r[idx[2:0]]) pick = idx[2:0];
        end
        return pick;
    endfunction

    assign w_winner   = rr_pick(req, r_rr_ptr);
    assign w_xfer     = (r_state == LOCK) && req[r_owner] && (r_credit_cnt != '0);
    assign rd_en      = w_xfer ? (5'b00001 << r_owner) : 5'b00000;
    assign flit_out_v = |rd_en;
    assign sel_out    = r_sel;
    assign busy       = (r_state == LOCK);
    assign credit_cnt = r_credit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel        <= 5'b00000;
            r_owner      <= 3'd0;
            r_rr_ptr     <= 3'd0;
            r_credit_cnt <= CRED_MAX;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_credit_cnt <= w_credit_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = LOCK;
                    w_owner_nxt = w_winner;
                    w_sel_nxt   = 5'b00001 << w_winner;
                end
            end
            LOCK: begin
                // Only the tail pop releases the port; bubbles and stalls hold it.
                if (w_xfer && tail[r_owner]) begin
                    w_state_nxt  = IDLE;
                    w_sel_nxt    = 5'b00000;
                    w_rr_ptr_nxt = (r_owner == 3'd4) ? 3'd0 : r_owner + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = 5'b00000;
            end
        endcase
    end

    always_comb begin
        w_credit_nxt = r_credit_cnt;
        if (w_xfer && !credit_in)
            w_credit_nxt = r_credit_cnt - 1'b1;
        else if (!w_xfer && credit_in && r_credit_cnt != CRED_MAX)
            w_credit_nxt = r_credit_cnt + 1'b1;
    end

    // A returned credit with the counter already full means the downstream over-returned.
    a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(credit_in && !w_xfer && r_credit_cnt == CRED_MAX));

endmodule

// File: tb/tb_out_port_arbiter.sv
// tb/tb_out_port_arbiter.sv - randomized and directed bench for out_port_arbiter against a behavioural model
module tb_out_port_arbiter;
    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic       credit_in = 1'b0;
    logic [4:0] sel_out;
    logic [4:0] rd_en;
    logic       flit_out_v;
    logic [2:0] credit_cnt;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    int m_owner;
    int m_ptr;
    int m_cred;

    out_port_arbiter #(.CREDITS(CREDITS), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .tail(tail), .credit_in(credit_in),
        .sel_out(sel_out), .rd_en(rd_en), .flit_out_v(flit_out_v),
        .credit_cnt(credit_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cred  = CREDITS;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; tail = '0; credit_in = 1'b0;
        #1;
        check("rst_sel", sel_out, 5'b00000);
        check("rst_busy", busy, 1'b0);
        check("rst_rd", rd_en, 5'b00000);
        check("rst_cred", credit_cnt, CREDITS);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle: drive at negedge, compare against the model, advance the model at posedge.
    task automatic step(input logic [4:0] rq, input logic [4:0] tl, input logic ci);
        bit         xfer;
        logic [4:0] exp_rd, exp_sel;
        xfer = (m_owner >= 0) && rq[m_owner] && (m_cred > 0);
        if (ci && !xfer && m_cred == CREDITS) ci = 1'b0;
        req = rq; tail = tl; credit_in = ci;
        exp_rd  = xfer ? 5'(1 << m_owner) : 5'b0;
        exp_sel = (m_owner >= 0) ? 5'(1 << m_owner) : 5'b0;
        #1;
        check("rd_en", rd_en, exp_rd);
        check("flit_v", flit_out_v, xfer);
        check("sel_out", sel_out, exp_sel);
        check("busy", busy, m_owner >= 0);
        check("credit", credit_cnt, m_cred);
        @(posedge clk);
        if (m_owner < 0) begin
            for (int k = 0; k < 5; k++) begin
                if (m_owner < 0 && rq[(m_ptr + k) % 5]) m_owner = (m_ptr + k) % 5;
            end
        end else if (xfer && tl[m_owner]) begin
            m_ptr   = (m_owner + 1) % 5;
            m_owner = -1;
        end
        m_cred = m_cred + int'(ci) - int'(xfer);
        if (m_cred > CREDITS) m_cred = CREDITS;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        repeat (3) step(5'b0, 5'b0, 1'b0);

        // single-flit packet from W
        step(5'b00100, 5'b00100, 1'b0);
        check("sf_sel_lock", sel_out, 5'b00100);
        step(5'b00100, 5'b00100, 1'b0);
        check("sf_sel_idle", sel_out, 5'b00000);
        check("sf_cred", credit_cnt, 3);
        step(5'b11111, 5'b01000, 1'b0);
        check("sf_ptr_S", sel_out, 5'b01000);
        step(5'b11111, 5'b01000, 1'b0);

        // wormhole lock and round-robin N -> E -> L
        do_reset();
        step(5'b10011, 5'b00000, 1'b1);
        check("wh_sel_N", sel_out, 5'b00001);
        step(5'b10011, 5'b00000, 1'b1);
        step(5'b10011, 5'b00000, 1'b1);
        step(5'b10011, 5'b00001, 1'b1);
        step(5'b10010, 5'b10010, 1'b1);
        check("wh_sel_E", sel_out, 5'b00010);
        step(5'b10010, 5'b10010, 1'b1);
        step(5'b10000, 5'b10000, 1'b1);
        check("wh_sel_L", sel_out, 5'b10000);
        step(5'b10000, 5'b10000, 1'b1);

        // credit stall, single credit release, simultaneous pop+credit, bubble
        do_reset();
        step(5'b00001, 5'b0, 1'b0);
        repeat (4) step(5'b00001, 5'b0, 1'b0);
        check("st_rd0", rd_en, 5'b0);
        check("st_busy", busy, 1'b1);
        check("st_cred0", credit_cnt, 0);
        step(5'b00001, 5'b0, 1'b1);
        check("st_pop1", rd_en, 5'b00001);
        step(5'b00001, 5'b0, 1'b0);
        step(5'b00000, 5'b0, 1'b1);
        step(5'b00000, 5'b0, 1'b1);
        check("sim_pre", credit_cnt, 2);
        step(5'b00001, 5'b0, 1'b1);
        check("sim_hold", credit_cnt, 2);
        repeat (3) step(5'b11110, 5'b11110, 1'b0);
        check("bub_sel", sel_out, 5'b00001);
        step(5'b00001, 5'b00001, 1'b0);

        // asynchronous reset mid-packet
        do_reset();
        step(5'b00010, 5'b0, 1'b0);
        step(5'b00010, 5'b0, 1'b0);
        req = 5'b00010;
        rst_n = 1'b0;
        #1;
        check("mr_sel", sel_out, 5'b0);
        check("mr_rd", rd_en, 5'b0);
        check("mr_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("mr_cred", credit_cnt, CREDITS);
        step(5'b0, 5'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rq, tl;
            rq = 5'($urandom) & 5'($urandom);
            if ($urandom_range(0, 3) != 0 && m_owner >= 0) rq[m_owner] = 1'b1;
            tl = 5'($urandom) & 5'($urandom);
            step(rq, tl, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
